handshake_ram_q: RTL and testbench

HANDSHAKE_RAM_Q -- requirements
Module: handshake_ram_q

---
 rtl/handshake_ram_q_if.sv | 37 +++
 rtl/handshake_ram_q.sv | 87 ++++++++
 tb/tb_handshake_ram_q.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_ram_q_if.sv
`default_nettype none
// ============================================================================
// Module      : handshake_ram_q_if
// Description : Command/response handshake bundle for handshake_ram_q.
//               master = command issuer / response consumer,
//               slave  = RAM + response queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface handshake_ram_q_if #(
    parameter int DATA_WD   = 8,
    parameter int ADDR_WD   = 4,
    parameter int RSP_DEPTH = 4
);
    localparam int c_CNT_WD = $clog2(RSP_DEPTH) + 1;

    logic                valid_in;
    logic                cmd_in;
    logic [ADDR_WD-1:0]  addr_in;
    logic [DATA_WD-1:0]  data_in;
    logic                ready_in;
    logic                valid_out;
    logic [DATA_WD-1:0]  data_out;
    logic [ADDR_WD-1:0]  addr_out;
    logic                ready_out;
    logic [c_CNT_WD-1:0] rsp_cnt;

    modport master (
        output valid_in, cmd_in, addr_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, addr_out, rsp_cnt
    );

    modport slave (
        input  valid_in, cmd_in, addr_in, data_in, ready_out,
        output ready_in, valid_out, data_out, addr_out, rsp_cnt
    );
endinterface
`default_nettype wire

// File: rtl/handshake_ram_q.sv
`default_nettype none
// ============================================================================
// Module      : handshake_ram_q
// Description : Single-port RAM behind a valid/ready command port. Writes are
//               silent; reads push {addr, data} into a small response FIFO
//               drained through a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_ram_q #(
    parameter int DATA_WD   = 8,
    parameter int ADDR_WD   = 4,
    parameter int RSP_DEPTH = 4
) (
    input  wire              clk,
    input  wire              rstn,
    handshake_ram_q_if.slave bus
);
    localparam int c_PTR_WD = $clog2(RSP_DEPTH);
    localparam int c_CNT_WD = c_PTR_WD + 1;
    localparam int c_WORDS  = 2 ** ADDR_WD;

    logic [DATA_WD-1:0]  r_mem    [c_WORDS];
    logic [DATA_WD-1:0]  r_q_data [RSP_DEPTH];
    logic [ADDR_WD-1:0]  r_q_addr [RSP_DEPTH];
    logic [c_PTR_WD-1:0] r_wr_ptr;
    logic [c_PTR_WD-1:0] r_rd_ptr;
    logic [c_CNT_WD-1:0] r_cnt;

    logic w_full;
    logic w_empty;
    logic w_fire_in;
    logic w_fire_out;
    logic w_push;
    logic w_wr;

    assign w_full     = (r_cnt == c_CNT_WD'(RSP_DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign w_fire_out = !w_empty && bus.ready_out;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign bus.ready_in = !w_full || w_fire_out;
    assign w_fire_in  = bus.valid_in && bus.ready_in;
    // Commands presented while reset is asserted are dropped entirely.
    assign w_push     = rstn && w_fire_in && !bus.cmd_in;
    assign w_wr       = rstn && w_fire_in && bus.cmd_in;

    assign bus.valid_out = !w_empty;
    assign bus.data_out  = w_empty ? '0 : r_q_data[r_rd_ptr];
    assign bus.addr_out  = w_empty ? '0 : r_q_addr[r_rd_ptr];
    assign bus.rsp_cnt   = r_cnt;

    // Storage array: written on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[bus.addr_in] <= bus.data_in;
        end
    end

    // Response payload slots: capture address and current RAM word on a read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= r_mem[bus.addr_in];
            r_q_addr[r_wr_ptr] <= bus.addr_in;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fire_out) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_fire_out) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_fire_out) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_handshake_ram_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_ram_q
// Description : Directed and randomized self-checking bench for handshake_ram_q.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_ram_q;
    localparam int c_DW = 8;
    localparam int c_AW = 4;
    localparam int c_DEPTH = 4;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    handshake_ram_q_if #(.DATA_WD(c_DW), .ADDR_WD(c_AW), .RSP_DEPTH(c_DEPTH)) bus ();

    handshake_ram_q #(.DATA_WD(c_DW), .ADDR_WD(c_AW), .RSP_DEPTH(c_DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_in  = 1'b0;
        bus.cmd_in    = 1'b0;
        bus.addr_in   = '0;
        bus.data_in   = '0;
        bus.ready_out = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
        checks += 5;
        if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
        if (bus.rsp_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.rsp_cnt); end
        if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.data_out); end
        if (bus.addr_out !== 4'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.addr_out); end
        if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready_in); end
    endtask

    task automatic test_raw();
        bus.ready_out = 1'b1;
        bus.valid_in  = 1'b1;
        bus.cmd_in    = 1'b1;
        bus.addr_in   = 4'd3;
        bus.data_in   = 8'hA5;
        tick();
        bus.cmd_in = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL raw_no_rsp_for_write got=%b exp=0", bus.valid_out); end
        tick();
        bus.valid_in = 1'b0;
        #1;
        checks += 4;
        if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL raw_valid got=%b exp=1", bus.valid_out); end
        if (bus.data_out !== 8'hA5) begin failures++; $display("FAIL raw_data got=%h exp=a5", bus.data_out); end
        if (bus.addr_out !== 4'd3) begin failures++; $display("FAIL raw_addr got=%h exp=3", bus.addr_out); end
        if (bus.rsp_cnt !== 3'd1) begin failures++; $display("FAIL raw_cnt got=%0d exp=1", bus.rsp_cnt); end
        tick();
        checks++;
        if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL raw_drained got=%b exp=0", bus.valid_out); end
    endtask

    task automatic test_backpressure();
        // Preload addresses 0..4 with 8'h10+i while the queue is empty.
        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        bus.cmd_in    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.addr_in = 4'(i);
            bus.data_in = 8'(8'h10 + i);
            tick();
        end
        bus.cmd_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.addr_in = 4'(i);
            #1;
            checks++;
            if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL bp_accept%0d got=%b exp=1", i, bus.ready_in); end
            tick();
        end
        bus.addr_in = 4'd4;
        #1;
        checks += 2;
        if (bus.ready_in !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", bus.ready_in); end
        if (bus.rsp_cnt !== 3'd4) begin failures++; $display("FAIL bp_full_cnt got=%0d exp=4", bus.rsp_cnt); end
        tick();
        checks++;
        if (bus.rsp_cnt !== 3'd4) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=4", bus.rsp_cnt); end
        bus.ready_out = 1'b1;
        #1;
        checks++;
        if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL bp_pop_ready got=%b exp=1", bus.ready_in); end
        tick();
        bus.valid_in = 1'b0;
        #1;
        checks++;
        if (bus.rsp_cnt !== 3'd4) begin failures++; $display("FAIL bp_pushpop_cnt got=%0d exp=4", bus.rsp_cnt); end
        for (int i = 1; i < 5; i++) begin
            checks += 2;
            if (bus.addr_out !== 4'(i)) begin failures++; $display("FAIL bp_order_addr%0d got=%h exp=%h", i, bus.addr_out, 4'(i)); end
            if (bus.data_out !== 8'(8'h10 + i)) begin failures++; $display("FAIL bp_order_data%0d got=%h exp=%h", i, bus.data_out, 8'(8'h10 + i)); end
            tick();
        end
        checks++;
        if (bus.rsp_cnt !== 3'd0) begin failures++; $display("FAIL bp_empty_cnt got=%0d exp=0", bus.rsp_cnt); end
    endtask

    task automatic test_back_to_back();
        bus.ready_out = 1'b1;
        bus.valid_in  = 1'b1;
        bus.cmd_in    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.addr_in = 4'(i);
            bus.data_in = 8'(i + 1);
            #1;
            checks++;
            if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL b2b_wr_ready%0d got=%b exp=1", i, bus.ready_in); end
            tick();
        end
        bus.cmd_in = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            if (i == 16) bus.valid_in = 1'b0;
            else bus.addr_in = 4'(i);
            #1;
            if (i < 16) begin
                checks++;
                if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL b2b_rd_ready%0d got=%b exp=1", i, bus.ready_in); end
            end
            if (i > 0) begin
                checks += 2;
                if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL b2b_valid%0d got=%b exp=1", i, bus.valid_out); end
                if (bus.data_out !== 8'(i)) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, bus.data_out, 8'(i)); end
            end
            tick();
        end
        checks++;
        if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", bus.valid_out); end
    endtask

    task automatic test_stall_hold();
        // Memory holds addr+1 at each address from the previous test.
        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        bus.cmd_in    = 1'b0;
        bus.addr_in   = 4'd5;
        tick();
        bus.addr_in   = 4'd6;
        tick();
        bus.valid_in  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks += 4;
            if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL hold_valid%0d got=%b exp=1", i, bus.valid_out); end
            if (bus.data_out !== 8'd6) begin failures++; $display("FAIL hold_data%0d got=%h exp=06", i, bus.data_out); end
            if (bus.addr_out !== 4'd5) begin failures++; $display("FAIL hold_addr%0d got=%h exp=5", i, bus.addr_out); end
            if (bus.rsp_cnt !== 3'd2) begin failures++; $display("FAIL hold_cnt%0d got=%0d exp=2", i, bus.rsp_cnt); end
            tick();
        end
        bus.ready_out = 1'b1;
        tick();
        checks += 3;
        if (bus.rsp_cnt !== 3'd1) begin failures++; $display("FAIL hold_pop1_cnt got=%0d exp=1", bus.rsp_cnt); end
        if (bus.data_out !== 8'd7) begin failures++; $display("FAIL hold_pop1_data got=%h exp=07", bus.data_out); end
        if (bus.addr_out !== 4'd6) begin failures++; $display("FAIL hold_pop1_addr got=%h exp=6", bus.addr_out); end
        tick();
        checks += 2;
        if (bus.rsp_cnt !== 3'd0) begin failures++; $display("FAIL hold_pop2_cnt got=%0d exp=0", bus.rsp_cnt); end
        if (bus.data_out !== 8'd0) begin failures++; $display("FAIL hold_empty_data got=%h exp=00", bus.data_out); end
    endtask

    task automatic test_reset_mid();
        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        bus.cmd_in    = 1'b0;
        for (int i = 7; i < 10; i++) begin
            bus.addr_in = 4'(i);
            tick();
        end
        checks++;
        if (bus.rsp_cnt !== 3'd3) begin failures++; $display("FAIL rmid_pre_cnt got=%0d exp=3", bus.rsp_cnt); end
        // A write presented during reset must be dropped.
        rstn = 1'b0;
        bus.cmd_in  = 1'b1;
        bus.addr_in = 4'd7;
        bus.data_in = 8'hEE;
        tick();
        rstn = 1'b1;
        bus.valid_in = 1'b0;
        #1;
        checks += 4;
        if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", bus.valid_out); end
        if (bus.rsp_cnt !== 3'd0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", bus.rsp_cnt); end
        if (bus.data_out !== 8'd0) begin failures++; $display("FAIL rmid_data got=%h exp=00", bus.data_out); end
        if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", bus.ready_in); end
        bus.valid_in = 1'b1;
        bus.cmd_in   = 1'b0;
        bus.addr_in  = 4'd7;
        tick();
        bus.valid_in = 1'b0;
        #1;
        checks += 2;
        if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL rmid_read_valid got=%b exp=1", bus.valid_out); end
        if (bus.data_out !== 8'd8) begin failures++; $display("FAIL rmid_retained got=%h exp=08", bus.data_out); end
        bus.ready_out = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [c_DW-1:0]        mem [16];
        logic [c_AW+c_DW-1:0]   q [$];
        logic                   exp_ready;
        logic                   f_in;
        logic                   f_out;
        int                     cyc_fail;
        cyc_fail = 0;
        bus.ready_out = 1'b1;
        bus.valid_in  = 1'b1;
        bus.cmd_in    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.addr_in = 4'(i);
            bus.data_in = 8'(i) ^ 8'h5A;
            mem[i] = 8'(i) ^ 8'h5A;
            tick();
        end
        bus.valid_in = 1'b0;
        tick();
        for (int c = 0; c < 10000; c++) begin
            bus.valid_in  = 1'($urandom_range(0, 1));
            bus.cmd_in    = 1'($urandom_range(0, 1));
            bus.addr_in   = 4'($urandom_range(0, 15));
            bus.data_in   = 8'($urandom_range(0, 255));
            bus.ready_out = 1'($urandom_range(0, 1));
            #1;
            exp_ready = (q.size() < c_DEPTH) || (q.size() != 0 && bus.ready_out);
            checks++;
            if (bus.ready_in !== exp_ready ||
                bus.rsp_cnt !== 3'(q.size()) ||
                bus.valid_out !== (q.size() != 0) ||
                (q.size() != 0 && {bus.addr_out, bus.data_out} !== q[0])) begin
                failures++;
                if (cyc_fail < 10)
                    $display("FAIL rand_cycle%0d got rdy=%b cnt=%0d vld=%b a=%h d=%h exp rdy=%b cnt=%0d head=%h",
                             c, bus.ready_in, bus.rsp_cnt, bus.valid_out, bus.addr_out, bus.data_out,
                             exp_ready, q.size(), (q.size() != 0) ? q[0] : 12'h0);
                cyc_fail++;
            end
            f_out = (q.size() != 0) && bus.ready_out;
            f_in  = bus.valid_in && exp_ready;
            if (f_out) void'(q.pop_front());
            if (f_in) begin
                if (bus.cmd_in) mem[bus.addr_in] = bus.data_in;
                else q.push_back({bus.addr_in, mem[bus.addr_in]});
            end
            tick();
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        while (q.size() != 0) begin
            #1;
            checks++;
            if ({bus.addr_out, bus.data_out} !== q[0]) begin
                failures++;
                $display("FAIL rand_drain got=%h exp=%h", {bus.addr_out, bus.data_out}, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        checks++;
        if (bus.rsp_cnt !== 3'd0) begin failures++; $display("FAIL rand_final_cnt got=%0d exp=0", bus.rsp_cnt); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        idle_inputs();
        test_reset();
        test_raw();
        test_backpressure();
        test_back_to_back();
        test_stall_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
